// File: rtl/xor_decifrador_16bit.sv
// Receive-side XOR stream decryptor: ciphertext ^ Galois LFSR keystream, registered
// onto a valid/ready output, with the keystream resyncing to the seed every block_len words.
//
// state     | meaning
// sem_chave | no key loaded, input side closed
// ativo     | key loaded, words are decrypted
module xor_decifrador_16bit #(
   parameter int                WIDTH     = 16,
   parameter logic [WIDTH-1:0]  TAPS      = 16'hB400,
   parameter int                BLOCK_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chave_load,
   input  logic [WIDTH-1:0] chave,
   input  logic             ent_valid,
   output logic             ent_pronto,
   input  logic [WIDTH-1:0] ent_dado,
   output logic             sai_valid,
   input  logic             sai_pronto,
   output logic [WIDTH-1:0] sai_dado,
   output logic             bloco_fim
);

   localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_LEN - 1);

   typedef enum logic {
      SEM_CHAVE = 1'b0,
      ATIVO     = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lfsr, seed, chave_eff, lfsr_nxt;
   logic [CW-1:0]    cnt;
   logic             accept, ultimo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SEM_CHAVE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ent_pronto = 1'b0;
      if (chave_load) state_nxt = ATIVO;
      if ((state == ATIVO) && !chave_load && (!sai_valid || sai_pronto))
         ent_pronto = 1'b1;
   end

   // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
   assign chave_eff = (chave == '0) ? WIDTH'(1) : chave;
   assign lfsr_nxt  = {1'b0, lfsr[WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
   assign accept    = ent_valid & ent_pronto;
   assign ultimo    = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr      <= '0;
         seed      <= '0;
         cnt       <= '0;
         sai_valid <= 1'b0;
         sai_dado  <= '0;
         bloco_fim <= 1'b0;
      end else if (chave_load) begin
         seed      <= chave_eff;
         lfsr      <= chave_eff;
         cnt       <= '0;
         sai_valid <= 1'b0;
         bloco_fim <= 1'b0;
      end else if (accept) begin
         sai_dado  <= ent_dado ^ lfsr;
         sai_valid <= 1'b1;
         bloco_fim <= ultimo;
         if (ultimo) begin
            cnt  <= '0;
            lfsr <= seed;
         end else begin
            cnt  <= cnt + CW'(1);
            lfsr <= lfsr_nxt;
         end
      end else if (sai_valid && sai_pronto) begin
         sai_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xor_decifrador_16bit.sv
// Directed bench for xor_decifrador_16bit; a second instance with block_len=1 shares the stimulus.
module tb_xor_decifrador_16bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        chave_load;
   logic [15:0] chave;
   logic        ent_valid;
   logic [15:0] ent_dado;
   logic        sai_pronto;
   logic        ent_pronto, sai_valid, bloco_fim;
   logic [15:0] sai_dado;
   logic        ent_pronto1, sai_valid1, bloco_fim1;
   logic [15:0] sai_dado1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   xor_decifrador_16bit dut (
      .clk(clk), .rst(rst), .chave_load(chave_load), .chave(chave),
      .ent_valid(ent_valid), .ent_pronto(ent_pronto), .ent_dado(ent_dado),
      .sai_valid(sai_valid), .sai_pronto(sai_pronto), .sai_dado(sai_dado),
      .bloco_fim(bloco_fim)
   );

   xor_decifrador_16bit #(.BLOCK_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .chave_load(chave_load), .chave(chave),
      .ent_valid(ent_valid), .ent_pronto(ent_pronto1), .ent_dado(ent_dado),
      .sai_valid(sai_valid1), .sai_pronto(sai_pronto), .sai_dado(sai_dado1),
      .bloco_fim(bloco_fim1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [15:0] k);
      chave_load = 1'b1;
      chave      = k;
      ent_valid  = 1'b0;
      step();
      chave_load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; chave_load = 1'b0; chave = 16'h0; ent_valid = 1'b0;
      ent_dado = 16'h0; sai_pronto = 1'b1;
      step(); step();
      vectors++;
      if (sai_valid !== 1'b0 || sai_dado !== 16'h0 || bloco_fim !== 1'b0 || ent_pronto !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: got valid=%b dado=%h fim=%b pronto=%b, want 0 0000 0 0",
                  sai_valid, sai_dado, bloco_fim, ent_pronto);
      end
      #2 rst = 1'b0;
      ent_valid = 1'b1; ent_dado = 16'h5A5A;
      step(); step();
      vectors++;
      if (ent_pronto !== 1'b0 || sai_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL no_key_closed: got pronto=%b valid=%b, want 0 0", ent_pronto, sai_valid);
      end
      ent_valid = 1'b0;
   endtask

   task automatic test_basic();
      chave_load = 1'b1; chave = 16'hACE1; ent_valid = 1'b1; ent_dado = 16'h0000;
      #1;
      vectors++;
      if (ent_pronto !== 1'b0) begin
         miscompares++;
         $display("FAIL load_blocks_accept: got pronto=%b, want 0", ent_pronto);
      end
      step();
      chave_load = 1'b0;
      #1;
      vectors++;
      if (ent_pronto !== 1'b1 || sai_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL after_load: got pronto=%b valid=%b, want 1 0", ent_pronto, sai_valid);
      end
      step();
      vectors++;
      if (sai_valid !== 1'b1 || sai_dado !== 16'hACE1 || bloco_fim !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_word1: got valid=%b dado=%h fim=%b, want 1 ace1 0", sai_valid, sai_dado, bloco_fim);
      end
      ent_dado = 16'h1234;
      step();
      vectors++;
      if (sai_valid !== 1'b1 || sai_dado !== 16'hF044) begin
         miscompares++;
         $display("FAIL basic_word2: got valid=%b dado=%h, want 1 f044", sai_valid, sai_dado);
      end
      ent_valid = 1'b0;
      step();
      vectors++;
      if (sai_valid !== 1'b0 || sai_dado !== 16'hF044) begin
         miscompares++;
         $display("FAIL drain_keeps_data: got valid=%b dado=%h, want 0 f044", sai_valid, sai_dado);
      end
   endtask

   task automatic test_zero_key();
      load_key(16'h0000);
      ent_valid = 1'b1; ent_dado = 16'h0000;
      step();
      vectors++;
      if (sai_dado !== 16'h0001) begin
         miscompares++;
         $display("FAIL zero_key_w1: got %h, want 0001", sai_dado);
      end
      step();
      vectors++;
      if (sai_dado !== 16'hB400) begin
         miscompares++;
         $display("FAIL zero_key_w2: got %h, want b400", sai_dado);
      end
      ent_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      load_key(16'hACE1);
      ent_valid = 1'b1; ent_dado = 16'h0000;
      step();
      sai_pronto = 1'b0; ent_dado = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (ent_pronto !== 1'b0 || sai_valid !== 1'b1 || sai_dado !== 16'hACE1) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: got pronto=%b valid=%b dado=%h, want 0 1 ace1",
                     i, ent_pronto, sai_valid, sai_dado);
         end
         step();
      end
      sai_pronto = 1'b1;
      #1;
      vectors++;
      if (ent_pronto !== 1'b1) begin
         miscompares++;
         $display("FAIL release_pronto: got %b, want 1", ent_pronto);
      end
      step();
      vectors++;
      if (sai_valid !== 1'b1 || sai_dado !== 16'hF044) begin
         miscompares++;
         $display("FAIL after_hold_word: got valid=%b dado=%h, want 1 f044", sai_valid, sai_dado);
      end
      ent_valid = 1'b0;
      step();
   endtask

   task automatic test_block_wrap();
      logic [15:0] exp_ks [9];
      exp_ks = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E,
                 16'h0E27, 16'hB313, 16'hED89, 16'hACE1};
      load_key(16'hACE1);
      ent_valid = 1'b1; ent_dado = 16'h0000;
      for (int i = 0; i < 9; i++) begin
         step();
         vectors++;
         if (sai_valid !== 1'b1 || sai_dado !== exp_ks[i] || bloco_fim !== (i == 7)) begin
            miscompares++;
            $display("FAIL wrap_word%0d: got valid=%b dado=%h fim=%b, want 1 %h %b",
                     i + 1, sai_valid, sai_dado, bloco_fim, exp_ks[i], (i == 7));
         end
         vectors++;
         if (sai_dado1 !== 16'hACE1 || bloco_fim1 !== 1'b1) begin
            miscompares++;
            $display("FAIL len1_word%0d: got dado=%h fim=%b, want ace1 1", i + 1, sai_dado1, bloco_fim1);
         end
      end
      ent_valid = 1'b0;
      step();
   endtask

   task automatic test_reload();
      load_key(16'hACE1);
      ent_valid = 1'b1; ent_dado = 16'h0000;
      step();
      chave_load = 1'b1; chave = 16'h0F0F; ent_dado = 16'h5555;
      #1;
      vectors++;
      if (ent_pronto !== 1'b0 || sai_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_cycle: got pronto=%b valid=%b, want 0 1", ent_pronto, sai_valid);
      end
      step();
      chave_load = 1'b0; ent_dado = 16'h0000;
      vectors++;
      if (sai_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_discard: got valid=%b, want 0", sai_valid);
      end
      step();
      vectors++;
      if (sai_valid !== 1'b1 || sai_dado !== 16'h0F0F) begin
         miscompares++;
         $display("FAIL reload_first: got valid=%b dado=%h, want 1 0f0f", sai_valid, sai_dado);
      end
      ent_valid = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      load_key(16'hACE1);
      ent_valid = 1'b1; ent_dado = 16'hFFFF;
      step(); step();
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (sai_valid !== 1'b0 || sai_dado !== 16'h0 || bloco_fim !== 1'b0 || ent_pronto !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got valid=%b dado=%h fim=%b pronto=%b, want 0 0000 0 0",
                  sai_valid, sai_dado, bloco_fim, ent_pronto);
      end
      #1 rst = 1'b0;
      step(); step();
      vectors++;
      if (ent_pronto !== 1'b0 || sai_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_closed: got pronto=%b valid=%b, want 0 0", ent_pronto, sai_valid);
      end
      load_key(16'hACE1);
      ent_valid = 1'b1; ent_dado = 16'h0000;
      step();
      vectors++;
      if (sai_valid !== 1'b1 || sai_dado !== 16'hACE1) begin
         miscompares++;
         $display("FAIL post_reset_word: got valid=%b dado=%h, want 1 ace1", sai_valid, sai_dado);
      end
      ent_valid = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_key();
      test_backpressure();
      test_block_wrap();
      test_reload();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
